// File: rtl/frame_pkg.sv
// frame_pkg: shared constants, parser state encoding and the CRC-16/CCITT
// word-step function used by the frame parser and its bench model.
package frame_pkg;

  localparam logic [15:0] HDR_WORD  = 16'hE0E0;
  localparam logic [15:0] TRL_WORD  = 16'h0E0E;
  localparam int          MAX_WORDS = 8;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_HDR2,
    ST_CHAN,
    ST_BODY,
    ST_DROP
  } parser_state_t;

  // One 16-bit word of CRC-16/CCITT (poly 0x1021, init/xorout handled by the
  // caller, no reflection), MSB of the word first. q = crc ^ word.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic [15:0] word);
    logic [15:0] q;
    logic [15:0] c;
    q = crc ^ word;
    c[0]  = q[0]  ^ q[4]  ^ q[8]  ^ q[11] ^ q[12];
    c[1]  = q[1]  ^ q[5]  ^ q[9]  ^ q[12] ^ q[13];
    c[2]  = q[2]  ^ q[6]  ^ q[10] ^ q[13] ^ q[14];
    c[3]  = q[3]  ^ q[7]  ^ q[11] ^ q[14] ^ q[15];
    c[4]  = q[4]  ^ q[8]  ^ q[12] ^ q[15];
    c[5]  = q[0]  ^ q[4]  ^ q[5]  ^ q[8]  ^ q[9]  ^ q[11] ^ q[12] ^ q[13];
    c[6]  = q[1]  ^ q[5]  ^ q[6]  ^ q[9]  ^ q[10] ^ q[12] ^ q[13] ^ q[14];
    c[7]  = q[2]  ^ q[6]  ^ q[7]  ^ q[10] ^ q[11] ^ q[13] ^ q[14] ^ q[15];
    c[8]  = q[3]  ^ q[7]  ^ q[8]  ^ q[11] ^ q[12] ^ q[14] ^ q[15];
    c[9]  = q[4]  ^ q[8]  ^ q[9]  ^ q[12] ^ q[13] ^ q[15];
    c[10] = q[5]  ^ q[9]  ^ q[10] ^ q[13] ^ q[14];
    c[11] = q[6]  ^ q[10] ^ q[11] ^ q[14] ^ q[15];
    c[12] = q[0]  ^ q[4]  ^ q[7]  ^ q[8]  ^ q[15];
    c[13] = q[1]  ^ q[5]  ^ q[8]  ^ q[9];
    c[14] = q[2]  ^ q[6]  ^ q[9]  ^ q[10];
    c[15] = q[3]  ^ q[7]  ^ q[10] ^ q[11];
    return c;
  endfunction

endpackage

// File: rtl/crc16_word.sv
// crc16_word: registered CRC-16/CCITT accumulator, one 16-bit word per clock.
// Ports:
//   clk_in  - word clock
//   rst_n   - async active-low reset, clears the accumulator
//   i_clr   - synchronous clear to 16'h0000 (wins over i_en)
//   i_en    - fold i_word into the accumulator
//   i_word  - data word
//   o_crc   - current accumulator value
module crc16_word (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [15:0] i_word,
  output logic [15:0] o_crc
);
  import frame_pkg::*;

  logic [15:0] r_crc;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= 16'h0000;
    end else if (i_clr) begin
      r_crc <= 16'h0000;
    end else if (i_en) begin
      r_crc <= crc16_step(r_crc, i_word);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/frame_parser.sv
// frame_parser: hunts for the E0E0 E0E0 header in the 16-bit word stream,
// captures channel, payload (1..MAX_WORDS words), CRC and 0E0E 0E0E trailer,
// checks CRC-16/CCITT and presents each good frame as one FIFO write.
// Ports:
//   clk_in, rst_n   - word clock, async active-low reset
//   data_in         - stream word, sampled every edge (no valid qualifier)
//   fifo_full       - FIFO write side full, sampled at the frame-end edge only
//   frm_vld         - one-cycle FIFO write strobe for a good frame
//   frm_chan/len/data - frame record, updated at every frame end, then held
//   crc_ok/crc_err/len_err/chan_err/frm_drop - one-cycle frame-end flags
//
// state   | meaning
// --------+------------------------------------------------------------
// HUNT    | waiting for first header word
// HDR2    | first header seen, expect second header word
// CHAN    | current word is the channel word; clear payload/count/CRC
// BODY    | collecting payload through the two-word delay window
// DROP    | payload overflowed; wait for trailer, then report len_err
module frame_parser #(
  parameter int MAX_WORDS = frame_pkg::MAX_WORDS
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic [15:0]             data_in,
  input  logic                    fifo_full,
  output logic                    frm_vld,
  output logic [7:0]              frm_chan,
  output logic [3:0]              frm_len,
  output logic [MAX_WORDS*16-1:0] frm_data,
  output logic                    crc_ok,
  output logic                    crc_err,
  output logic                    len_err,
  output logic                    chan_err,
  output logic                    frm_drop
);
  import frame_pkg::*;

  localparam int DW = MAX_WORDS * 16;

  parser_state_t r_state, w_state_nxt;

  logic [15:0]   r_w1, r_w2;
  logic [1:0]    r_fill;
  logic [3:0]    r_cnt;
  logic [15:0]   r_chan_word;
  logic [DW-1:0] r_data;

  logic [15:0]   w_crc;
  logic          w_win_full;
  logic          w_trl_end;
  logic          w_payload;
  logic          w_overflow;
  logic          w_crc_en;
  logic          w_crc_clr;
  logic          w_chan_good;
  logic          w_frame_end;
  logic          w_vld, w_ok, w_err, w_len, w_chan, w_drop;

  crc16_word u_crc (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .i_clr  (w_crc_clr),
    .i_en   (w_crc_en),
    .i_word (r_w1),
    .o_crc  (w_crc)
  );

  // End of frame: trailer pair at data_in/w2 with a full window, so w1 holds
  // the received CRC and everything older has already been folded in.
  assign w_win_full  = (r_fill == 2'd2);
  assign w_trl_end   = (data_in == TRL_WORD) && (r_w2 == TRL_WORD) && w_win_full;
  assign w_payload   = (r_state == ST_BODY) && w_win_full && !w_trl_end;
  assign w_overflow  = w_payload && (r_cnt == 4'(MAX_WORDS));
  assign w_crc_en    = w_payload && !w_overflow;
  assign w_crc_clr   = (r_state == ST_CHAN);
  assign w_chan_good = (r_chan_word[15:8] == 8'h00) && $onehot(r_chan_word[7:0]);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_frame_end = 1'b0;
    w_vld       = 1'b0;
    w_ok        = 1'b0;
    w_err       = 1'b0;
    w_len       = 1'b0;
    w_chan      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (data_in == HDR_WORD) w_state_nxt = ST_HDR2;
      end
      ST_HDR2: begin
        w_state_nxt = (data_in == HDR_WORD) ? ST_CHAN : ST_HUNT;
      end
      ST_CHAN: begin
        w_state_nxt = ST_BODY;
      end
      ST_BODY: begin
        if (w_trl_end) begin
          w_state_nxt = ST_HUNT;
          w_frame_end = 1'b1;
          w_chan      = !w_chan_good;
          if (r_cnt == 4'd0) begin
            w_len = 1'b1;
          end else begin
            w_ok  = (w_crc == r_w1);
            w_err = (w_crc != r_w1);
          end
          // count is at most MAX_WORDS here; overflow would have left BODY
          if (w_ok && w_chan_good) begin
            w_vld  = !fifo_full;
            w_drop = fifo_full;
          end
        end else if (w_overflow) begin
          w_state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        if ((data_in == TRL_WORD) && (r_w2 == TRL_WORD)) begin
          w_state_nxt = ST_HUNT;
          w_frame_end = 1'b1;
          w_len       = 1'b1;
          w_chan      = !w_chan_good;
        end
      end
      default: w_state_nxt = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_w1        <= '0;
      r_w2        <= '0;
      r_fill      <= '0;
      r_cnt       <= '0;
      r_chan_word <= '0;
      r_data      <= '0;
    end else begin
      if (r_state == ST_CHAN) begin
        r_chan_word <= data_in;
        r_w1        <= '0;
        r_w2        <= '0;
        r_fill      <= '0;
        r_cnt       <= '0;
        r_data      <= '0;
      end else if ((r_state == ST_BODY) || (r_state == ST_DROP)) begin
        r_w2 <= data_in;
        r_w1 <= r_w2;
        if (r_fill != 2'd2) r_fill <= r_fill + 2'd1;
        if (w_crc_en) begin
          r_data <= {r_data[DW-17:0], r_w1};
          r_cnt  <= r_cnt + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      frm_vld  <= 1'b0;
      crc_ok   <= 1'b0;
      crc_err  <= 1'b0;
      len_err  <= 1'b0;
      chan_err <= 1'b0;
      frm_drop <= 1'b0;
      frm_chan <= '0;
      frm_len  <= '0;
      frm_data <= '0;
    end else begin
      frm_vld  <= w_vld;
      crc_ok   <= w_ok;
      crc_err  <= w_err;
      len_err  <= w_len;
      chan_err <= w_chan;
      frm_drop <= w_drop;
      if (w_frame_end) begin
        frm_chan <= r_chan_word[7:0];
        frm_len  <= r_cnt;
        frm_data <= r_data;
      end
    end
  end

endmodule

// File: tb/tb_frame_parser.sv
module tb_frame_parser;
  import frame_pkg::*;

  localparam logic [5:0] F_VLD  = 6'b100000;
  localparam logic [5:0] F_OK   = 6'b010000;
  localparam logic [5:0] F_ERR  = 6'b001000;
  localparam logic [5:0] F_LEN  = 6'b000100;
  localparam logic [5:0] F_CHAN = 6'b000010;
  localparam logic [5:0] F_DROP = 6'b000001;

  typedef struct packed {
    logic [15:0]       chan_word;
    logic [4:0]        n;
    logic [15:0][15:0] pl;
    logic              bad_crc;
    logic [15:0]       crc_val;
    logic              ff_early;
    logic              ff_last;
    logic              chk_data;
    logic [5:0]        exp_flags;
  } vec_t;

  logic         clk_in = 1'b0;
  logic         rst_n;
  logic [15:0]  data_in;
  logic         fifo_full;
  logic         frm_vld, crc_ok, crc_err, len_err, chan_err, frm_drop;
  logic [7:0]   frm_chan;
  logic [3:0]   frm_len;
  logic [127:0] frm_data;
  logic [5:0]   flags;

  int n_checks = 0;
  int n_fail   = 0;

  frame_parser dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .fifo_full (fifo_full),
    .frm_vld   (frm_vld),
    .frm_chan  (frm_chan),
    .frm_len   (frm_len),
    .frm_data  (frm_data),
    .crc_ok    (crc_ok),
    .crc_err   (crc_err),
    .len_err   (len_err),
    .chan_err  (chan_err),
    .frm_drop  (frm_drop)
  );

  always #5 clk_in = ~clk_in;

  assign flags = {frm_vld, crc_ok, crc_err, len_err, chan_err, frm_drop};

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one word, let the DUT sample it, then settle past the edge.
  task automatic step(input logic [15:0] w);
    data_in = w;
    @(posedge clk_in);
    #1;
  endtask

  // Bit-serial reference CRC, independent of the packaged parallel form.
  function automatic logic [15:0] crc_serial(input logic [15:0] crc, input logic [15:0] w);
    logic [15:0] c;
    logic fb;
    c = crc;
    for (int b = 15; b >= 0; b--) begin
      fb = c[15] ^ w[b];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  function automatic vec_t mk(input logic [15:0] cw, input int n, input logic [5:0] fl,
                              input logic chk_d);
    vec_t v;
    v = '0;
    v.chan_word = cw;
    v.n         = 5'(n);
    v.exp_flags = fl;
    v.chk_data  = chk_d;
    return v;
  endfunction

  task automatic send_frame(input vec_t v, input string tag);
    logic [15:0]  crc;
    logic [127:0] exp_data;
    logic [5:0]   seen;
    crc      = 16'h0000;
    exp_data = '0;
    seen     = '0;
    fifo_full = v.ff_early;
    step(HDR_WORD);
    chk({tag, " prev_pulse_one_cycle"}, {122'd0, flags}, 128'd0);
    step(HDR_WORD);
    seen |= flags;
    step(v.chan_word);
    seen |= flags;
    for (int i = 0; i < int'(v.n); i++) begin
      step(v.pl[i]);
      seen |= flags;
      crc = crc16_step(crc, v.pl[i]);
      if (i < 8) exp_data = {exp_data[111:0], v.pl[i]};
    end
    step(v.bad_crc ? v.crc_val : crc);
    seen |= flags;
    step(TRL_WORD);
    seen |= flags;
    fifo_full = v.ff_last;
    step(TRL_WORD);
    fifo_full = 1'b0;
    chk({tag, " early_pulses"}, {122'd0, seen}, 128'd0);
    chk({tag, " flags"}, {122'd0, flags}, {122'd0, v.exp_flags});
    if (v.chk_data) begin
      chk({tag, " frm_chan"}, {120'd0, frm_chan}, {120'd0, v.chan_word[7:0]});
      chk({tag, " frm_len"}, {124'd0, frm_len}, {123'd0, v.n});
      chk({tag, " frm_data"}, frm_data, exp_data);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    logic [15:0] big [8];
    logic [15:0] cs_a [6];
    logic [15:0] cs_w [6];
    logic [5:0]  seen;
    vec_t v;

    big  = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'hFEDC, 16'hBA98, 16'h7654, 16'h3210};
    cs_a = '{16'h0000, 16'h0000, 16'hFFFF, 16'h1D0F, 16'h0000, 16'hABCD};
    cs_w = '{16'hA55A, 16'h1234, 16'h0000, 16'h8001, 16'h0001, 16'hFFFF};

    vecs[0] = mk(16'h0001, 1, F_VLD | F_OK, 1'b1);
    vecs[0].pl[0] = 16'hA55A;
    vecs[1] = mk(16'h0002, 8, F_VLD | F_OK, 1'b1);
    for (int i = 0; i < 8; i++) vecs[1].pl[i] = big[i];
    vecs[2] = mk(16'h0004, 1, F_VLD | F_OK, 1'b1);
    vecs[2].pl[0] = 16'h1234;
    vecs[3] = mk(16'h0001, 1, F_ERR, 1'b0);
    vecs[3].pl[0] = 16'h1234;
    vecs[3].bad_crc = 1'b1;
    vecs[3].crc_val = 16'hFFFF;
    vecs[4] = mk(16'h0020, 16, F_LEN, 1'b0);
    for (int i = 0; i < 16; i++) vecs[4].pl[i] = 16'hAAAA;
    vecs[5] = mk(16'h0001, 2, F_VLD | F_OK, 1'b1);
    vecs[5].pl[0] = HDR_WORD;
    vecs[5].pl[1] = HDR_WORD;
    vecs[6] = mk(16'h0003, 1, F_OK | F_CHAN, 1'b0);
    vecs[6].pl[0] = 16'hBEEF;
    vecs[7] = mk(16'h0008, 3, F_OK | F_DROP, 1'b1);
    vecs[7].pl[0] = 16'hCAFE;
    vecs[7].pl[1] = 16'hF00D;
    vecs[7].pl[2] = 16'h0001;
    vecs[7].ff_last = 1'b1;
    vecs[8] = mk(16'h0101, 1, F_OK | F_CHAN, 1'b0);
    vecs[8].pl[0] = 16'h7777;
    vecs[9] = mk(16'h0001, 0, F_LEN, 1'b0);
    vecs[10] = mk(16'h0010, 9, F_LEN, 1'b0);
    for (int i = 0; i < 9; i++) vecs[10].pl[i] = 16'h1000 + 16'(i);
    vecs[11] = mk(16'h0080, 1, F_VLD | F_OK, 1'b1);
    vecs[11].pl[0] = 16'hFFFF;
    vecs[11].ff_early = 1'b1;

    // Packaged parallel CRC against the bit-serial definition.
    for (int i = 0; i < 6; i++)
      chk($sformatf("crc16_step[%0d]", i), {112'd0, crc16_step(cs_a[i], cs_w[i])},
          {112'd0, crc_serial(cs_a[i], cs_w[i])});

    // Reset state.
    rst_n     = 1'b0;
    data_in   = 16'h0000;
    fifo_full = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset flags", {122'd0, flags}, 128'd0);
    chk("reset frm_chan", {120'd0, frm_chan}, 128'd0);
    chk("reset frm_len", {124'd0, frm_len}, 128'd0);
    chk("reset frm_data", frm_data, 128'd0);
    rst_n = 1'b1;
    step(16'h0000);

    for (int k = 0; k < 12; k++) send_frame(vecs[k], $sformatf("vec%0d", k));
    step(16'h0000);
    chk("vec11 pulse_one_cycle", {122'd0, flags}, 128'd0);
    chk("hold frm_data", frm_data, 128'h0000_FFFF);

    // Reset during payload aborts the frame silently.
    step(HDR_WORD);
    step(HDR_WORD);
    step(16'h0001);
    step(16'h1111);
    step(16'h2222);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset frm_data", frm_data, 128'd0);
    chk("midreset frm_chan", {120'd0, frm_chan}, 128'd0);
    step(16'h3333);
    step(16'h4444);
    rst_n = 1'b1;
    seen = '0;
    step(16'h5555);
    seen |= flags;
    step(TRL_WORD);
    seen |= flags;
    step(TRL_WORD);
    seen |= flags;
    step(16'h0000);
    seen |= flags;
    chk("aborted frame pulses", {122'd0, seen}, 128'd0);
    send_frame(vecs[0], "post_reset");

    // A lone header word followed by a non-header returns to hunting.
    step(HDR_WORD);
    step(16'h1234);
    v = vecs[2];
    send_frame(v, "false_hdr");
    step(16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_parser.md
# frame_parser

Input-side parser in the `clk_in` domain. It hunts for the 32-bit header in the 16-bit big-endian word stream, captures the channel byte, payload (1–8 words), CRC and trailer, and checks CRC-16/CCITT. Each good frame is presented as one record to the write side of the async frame FIFO that feeds the `clk_out` Gray/serial output stage. Bad frames are dropped and flagged.

## Interface
- `MAX_WORDS`, default 8: maximum payload words (128 bits).
- `clk_in`  in  1: word clock, 50–100 MHz; all logic on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `data_in`  in  16: stream word, sampled every `clk_in` edge; there is no valid qualifier.
- `fifo_full`  in  1: FIFO write side is full.
- `frm_vld`  out  1: one-cycle FIFO write strobe for a good frame.
- `frm_chan`  out  8: one-hot channel.
- `frm_len`  out  4: payload words, 1–8.
- `frm_data`  out  128: payload, right-aligned. The first word received is the most significant; unused upper bits are 0.
- `crc_ok`  out  1: one-cycle pulse when the CRC matches.
- `crc_err`  out  1: one-cycle pulse when the CRC mismatches.
- `len_err`  out  1: one-cycle pulse for 0 payload words or more than `MAX_WORDS`.
- `chan_err`  out  1: one-cycle pulse when the channel byte is not one-hot or the high byte is nonzero.
- `frm_drop`  out  1: one-cycle pulse when a good frame is lost because `fifo_full` is high.

## Operation
- Frame layout: E0E0, E0E0, {8'h00, chan}, payload×N, CRC, 0E0E, 0E0E. Frames may be back-to-back with no idle words.
- States:
  - HUNT: `data_in`==E0E0 goes to HDR2.
  - HDR2: E0E0 goes to CHAN; any other word goes to HUNT.
  - CHAN: latch the word; clear the payload, word count and CRC accumulator; go to BODY.
  - BODY: collect words.
  - DROP: wait for the trailer.
- BODY uses a two-word delay window w1 (older) and w2.
  - Each edge shifts `data_in` into w2 and w2 into w1.
  - The word leaving w1 is payload. It is appended to `frm_data` (shift left 16), fed to the CRC, and the count is incremented.
- End of frame is detected on the edge where `data_in`==0E0E, w2==0E0E and the window is full.
  - At that point w1 holds the received CRC.
  - The first trailer match ends the frame; payload is not escaped.
- CRC: init 16'h0000, no reflection, no final XOR, one word per step.
  - crc_next = crc16_step(crc, word), the standard 16-bit-parallel polynomial-0x1021 form.
  - With q = crc ^ word: bit 0 = q0^q4^q8^q11^q12, bit 15 = q3^q7^q10^q11.
- If a 9th payload word leaves w1, go to DROP. In DROP, 0E0E followed by 0E0E raises `len_err` and returns to HUNT. Header words seen inside BODY or DROP are ignored.
- Frame-end priority:
  - count==0: `len_err` only.
  - Otherwise `crc_ok` or `crc_err`.
  - `chan_err` is additionally raised if the channel is bad.
- `frm_vld` requires all of: CRC match, good channel, count 1–8, and `!fifo_full`. If everything else is good but the FIFO is full, raise `frm_drop` and do not raise `frm_vld`.

## Timing
- Reset: state HUNT, window, count and accumulators cleared. All outputs 0; data and channel outputs are held at 0.
- Reset mid-frame aborts the frame with no pulse. Parsing restarts only at a new header.
- Let trailer word 2 be sampled on edge N.
  - All result pulses and `frm_chan`, `frm_len`, `frm_data` are registered at edge N and are valid for exactly one cycle.
  - State is HUNT at edge N, so a header word sampled at N+1 is accepted.
- `frm_chan`, `frm_len` and `frm_data` hold their values until the next frame end.
- `fifo_full` is sampled at edge N only.
- Pulses never last more than one cycle. `crc_ok` and `crc_err` are mutually exclusive.

## Structure
- Shared package `frame_pkg`:
  - `HDR_WORD`=16'hE0E0, `TRL_WORD`=16'h0E0E.
  - `MAX_WORDS`.
  - Parser state enum.
  - Function `crc16_step` with the full 16-bit equation set. The same function is used by the test bench model.
- Sub-module `crc16_word`: registered accumulator with clear and enable, wrapping `crc16_step`.

## Test plan
- Ch1, payload A55A, CRC = crc16_step(0,16'hA55A) -> `frm_vld` and `crc_ok` one cycle, `frm_chan`=01, `frm_len`=1, `frm_data`=…A55A.
- Ch2, 128-bit payload 0123456789ABCDEFFEDCBA9876543210 with correct CRC, immediately followed by a ch3 frame 1234 -> two records, `frm_len` 8 then 1, no lost header.
- Ch1, payload 1234, CRC FFFF -> `crc_err` pulse, no `frm_vld`.
- Ch 0x20, 16 words of AAAA -> `len_err` pulse at trailer, no `frm_vld` or `crc_*`. The next good frame is parsed normally.
- Channel byte 0x03 with good CRC -> `crc_ok` and `chan_err`, no `frm_vld`. Good frame with `fifo_full`=1 at edge N -> `frm_drop`, no `frm_vld`.
- `rst_n` low during payload, then a good frame -> no pulses from the aborted frame; the good frame is emitted correctly.
